watch_sequencer: RTL
====================

WATCH_SEQUENCER -- requirements
Module: watch_sequencer

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, width of pc/addr; NSTAGES, default 4, number of checkpoints; LED_W, default 5, width of leds; TMO_W, default 16, width of timeout counter; TMO_LIMIT, default 1000, cycles allowed between stage advances.
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 pc  in  XLEN  core program counter; addr  in  XLEN  core data/ALU address; rdId  in  5  destination register; leds  in  LED_W  core LED output.
REQ-005 arm  in  1  start/restart sequence; cfg_we  in  1  config write strobe; cfg_stage  in  $clog2(NSTAGES)  target stage; cfg_sel  in  2  field (0 pc, 1 addr, 2 {rdId,leds}, 3 enable mask); cfg_wdata  in  XLEN  write data.
REQ-006 stage  out  $clog2(NSTAGES+1)  current stage index; hit  out  1  one-cycle advance pulse; done  out  1  sticky success; timeout  out  1  sticky failure; cfg_err  out  1  one-cycle rejected-write pulse; busy  out  1  high in ARMED.

Function
REQ-007 Each stage SHALL hold pc_ref (XLEN), addr_ref (XLEN), rd_ref (5), led_ref (LED_W) and mask (4 bits: [0] pc, [1] addr, [2] rdId, [3] leds).
REQ-008 cfg_sel=2 SHALL write rd_ref=cfg_wdata[4:0], led_ref=cfg_wdata[5+:LED_W]; cfg_sel=3 SHALL write mask=cfg_wdata[3:0].
REQ-009 Config writes SHALL take effect on the next edge and SHALL be accepted in IDLE, DONE, TIMEOUT only.
REQ-010 cfg_we in ARMED, or with cfg_stage>=NSTAGES, SHALL drop the write and pulse cfg_err for one cycle.
REQ-011 State machine SHALL have states IDLE, ARMED, DONE, TIMEOUT.
REQ-012 IDLE->ARMED on arm=1; stage<=0, timeout counter<=0, done<=0, timeout<=0.
REQ-013 In ARMED a stage SHALL match when every mask-enabled field equals its registered input sampled that cycle; mask=0 matches unconditionally.
REQ-014 On match: hit=1 for one cycle, stage<=stage+1, counter<=0; at most one stage advance per cycle.
REQ-015 Match of stage NSTAGES-1 SHALL go to DONE: done=1, stage=NSTAGES, busy=0.
REQ-016 No match: counter increments; when counter reaches TMO_LIMIT-1 with no match that cycle, go to TIMEOUT: timeout=1, stage holds.
REQ-017 Match and timeout limit in same cycle: match SHALL win.
REQ-018 Counter SHALL saturate, never wrap; TMO_LIMIT SHALL fit in TMO_W (elaboration check).
REQ-019 arm in ARMED, DONE or TIMEOUT SHALL restart: stage<=0, counter<=0, done/timeout cleared, no hit that cycle even if stage 0 matches; stage 0 evaluated next cycle.
REQ-020 hit, done, timeout, stage SHALL be registered (no combinational path from pc/addr/rdId/leds).
REQ-021 NSTAGES=1 SHALL be supported (single checkpoint).

Reset
REQ-022 reset=0 at a rising edge SHALL force IDLE, stage=0, hit=0, done=0, timeout=0, cfg_err=0, busy=0, counter=0, all masks=0, refs=0.
REQ-023 reset SHALL override arm and cfg_we in the same cycle; reset mid-sequence SHALL abort without hit.

Verification
REQ-024 Stage0 {pc=0x2C mask pc|leds, leds=0xE}, stage1 {rdId=0x1E, addr=0x36 mask addr|rd}, NSTAGES=2; drive pc=0x2C/leds=0xE then rdId=0x1E/addr=0x36 -> hit twice, done=1, stage=2.
REQ-025 Drive stage-1 match before stage-0 match -> no hit until stage 0 matches; order enforced.
REQ-026 TMO_LIMIT=10, arm, no matching inputs -> timeout=1 exactly 10 cycles after arm edge, stage=0, done=0.
REQ-027 cfg_we during ARMED -> cfg_err one-cycle pulse, stage refs unchanged (read back by rerun).
REQ-028 Assert reset=0 while stage=1 -> next cycle IDLE, stage=0, busy=0; arm again restarts from stage 0.
REQ-029 All masks=0, NSTAGES=4, arm -> hit on 4 consecutive cycles, done on the 4th post-arm edge.

Source files
------------

// File: rtl/watch_sequencer.sv
// Checkpoint watcher: walks NSTAGES programmable match conditions on the core's
// pc/addr/rdId/leds in order, ending in done or in timeout if progress stalls.
module watch_sequencer #(
  parameter int XLEN      = 32,
  parameter int NSTAGES   = 4,
  parameter int LED_W     = 5,
  parameter int TMO_W     = 16,
  parameter int TMO_LIMIT = 1000,
  localparam int SW  = (NSTAGES > 1) ? $clog2(NSTAGES) : 1,
  localparam int STW = $clog2(NSTAGES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [4:0]      rd_id_i,
  input  logic [LED_W-1:0] leds_i,
  input  logic            arm_i,
  input  logic            cfg_we_i,
  input  logic [SW-1:0]   cfg_stage_i,
  input  logic [1:0]      cfg_sel_i,
  input  logic [XLEN-1:0] cfg_wdata_i,
  output logic [STW-1:0]  stage_o,
  output logic            hit_o,
  output logic            done_o,
  output logic            timeout_o,
  output logic            cfg_err_o,
  output logic            busy_o,
  output logic [1:0]      state_o
);

  if (NSTAGES < 1 || XLEN < 5 + LED_W || TMO_LIMIT < 1 ||
      64'(TMO_LIMIT) > ((64'd1 << TMO_W) - 64'd1)) begin : g_param_check
    $error("watch_sequencer: illegal parameters (TMO_LIMIT must fit in TMO_W)");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TMO_LIMIT - 1);
  localparam logic [STW-1:0]   LAST_STAGE = STW'(NSTAGES - 1);
  localparam logic [STW-1:0]   END_STAGE  = STW'(NSTAGES);

  state_e           state_q, state_d;
  logic [STW-1:0]   stage_q, stage_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             cfg_err_q;

  logic [XLEN-1:0]  pc_q, addr_q;
  logic [4:0]       rd_q;
  logic [LED_W-1:0] led_q;

  logic [XLEN-1:0]  pc_ref_q   [NSTAGES];
  logic [XLEN-1:0]  addr_ref_q [NSTAGES];
  logic [4:0]       rd_ref_q   [NSTAGES];
  logic [LED_W-1:0] led_ref_q  [NSTAGES];
  logic [3:0]       mask_q     [NSTAGES];

  logic [SW-1:0]    cur;
  logic [3:0]       cur_mask;
  logic             stage_match;
  logic             cfg_reject;

  // Config port is a single-cycle strobe with no back-pressure: a write is either
  // committed on this edge or dropped and reported by a one-cycle cfg_err pulse.
  assign cfg_reject = (state_q == S_ARMED) || (int'(cfg_stage_i) >= NSTAGES);

  // Core signals are compared one cycle late so no input reaches hit/done/stage.
  assign cur = stage_q[SW-1:0];
  always_comb begin
    cur_mask    = mask_q[cur];
    stage_match = (!cur_mask[0] || (pc_q   == pc_ref_q[cur]))   &&
                  (!cur_mask[1] || (addr_q == addr_ref_q[cur])) &&
                  (!cur_mask[2] || (rd_q   == rd_ref_q[cur]))   &&
                  (!cur_mask[3] || (led_q  == led_ref_q[cur]));
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    done_d  = done_q;
    tmo_d   = tmo_q;
    if (arm_i) begin
      // Arm always restarts, and suppresses any match in the same cycle.
      state_d = S_ARMED;
      stage_d = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
    end else if (state_q == S_ARMED) begin
      if (stage_match) begin
        hit_d = 1'b1;
        cnt_d = '0;
        if (stage_q == LAST_STAGE) begin
          state_d = S_DONE;
          stage_d = END_STAGE;
          done_d  = 1'b1;
        end else begin
          stage_d = stage_q + STW'(1);
        end
      end else if (cnt_q >= TMO_LAST) begin
        state_d = S_TIMEOUT;
        tmo_d   = 1'b1;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      stage_q   <= '0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      pc_q      <= '0;
      addr_q    <= '0;
      rd_q      <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      cfg_err_q <= cfg_we_i && cfg_reject;
      pc_q      <= pc_i;
      addr_q    <= addr_i;
      rd_q      <= rd_id_i;
      led_q     <= leds_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSTAGES; i++) begin
        pc_ref_q[i]   <= '0;
        addr_ref_q[i] <= '0;
        rd_ref_q[i]   <= '0;
        led_ref_q[i]  <= '0;
        mask_q[i]     <= '0;
      end
    end else if (cfg_we_i && !cfg_reject) begin
      case (cfg_sel_i)
        2'd0: pc_ref_q[cfg_stage_i]   <= cfg_wdata_i;
        2'd1: addr_ref_q[cfg_stage_i] <= cfg_wdata_i;
        2'd2: begin
          rd_ref_q[cfg_stage_i]  <= cfg_wdata_i[4:0];
          led_ref_q[cfg_stage_i] <= cfg_wdata_i[5 +: LED_W];
        end
        default: mask_q[cfg_stage_i] <= cfg_wdata_i[3:0];
      endcase
    end
  end

  assign stage_o   = stage_q;
  assign hit_o     = hit_q;
  assign done_o    = done_q;
  assign timeout_o = tmo_q;
  assign cfg_err_o = cfg_err_q;
  assign busy_o    = (state_q == S_ARMED);
  assign state_o   = state_q;

endmodule
